spi_frame_slave: RTL

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_frame_slave_sample_fifo.sv | 62 ++++++
 rtl/spi_frame_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame slave: FSM state encoding,
// frame-width computation and a saturating 8-bit increment.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_ACTIVE,
        ST_COMMIT
    } state_t;

    function automatic int frame_width(input int addr_width, input int data_width);
        return 1 + addr_width + data_width;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/spi_frame_slave_sample_fifo.sv
// Sample FIFO feeding the SPI transmit register. A pop of an empty FIFO is
// ignored here (the caller counts it); a push while full is accepted only
// when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: receives {write flag, register number, value} frames
// into register-write strobes and streams FIFO samples back on MISO.
//
// state        | meaning
// ST_WAIT_IDLE | after reset, waiting for CS_n high before accepting a frame
// ST_IDLE      | CS_n high, waiting for CS_n falling edge
// ST_ACTIVE    | frame in progress, shifting MOSI in and MISO out
// ST_COMMIT    | one cycle after CS_n rise; write strobe high if frame valid
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SampleValid,
    input  logic [DATA_WIDTH-1:0] i_Sample,
    output logic                  o_SampleFull,
    output logic                  o_RegWriteEnable,
    output logic [ADDR_WIDTH-1:0] o_RegWriteNumber,
    output logic [DATA_WIDTH-1:0] o_RegWriteValue,
    output logic [7:0]            o_UnderflowCount,
    output logic [7:0]            o_OverflowCount,
    output logic [7:0]            o_FrameErrorCount,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_SCK,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO
);

    localparam int FW = frame_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [FW-1:0]         rx_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [DATA_WIDTH-1:0] val_q;
    logic [7:0]            under_q, over_q, ferr_q;

    logic                  cs_fall, cs_rise, sck_rise, sck_fall;
    logic                  frame_start;
    logic                  overflow_d;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign cs_fall  =  cs_prev_q & ~cs_sync_q;
    assign cs_rise  = ~cs_prev_q &  cs_sync_q;
    assign sck_rise = ~sck_prev_q &  sck_sync_q;
    assign sck_fall =  sck_prev_q & ~sck_sync_q;

    assign frame_start = (state_q == ST_IDLE) & cs_fall;
    assign overflow_d  = i_SampleValid & fifo_full & ~frame_start;

    sample_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .push_i (i_SampleValid),
        .data_i (i_Sample),
        .pop_i  (frame_start),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= i_SPI_CS_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sck_meta_q  <= i_SPI_SCK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= i_SPI_MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= ST_WAIT_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            we_q      <= 1'b0;
            num_q     <= '0;
            val_q     <= '0;
            under_q   <= '0;
            over_q    <= '0;
            ferr_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (overflow_d) begin
                over_q <= sat_inc8(over_q);
            end
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (cs_sync_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ST_ACTIVE;
                        bit_cnt_q <= '0;
                        rx_q      <= '0;
                        tx_q      <= fifo_empty ? '0 : fifo_head;
                        if (fifo_empty) begin
                            under_q <= sat_inc8(under_q);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (sck_rise) begin
                        rx_q <= {rx_q[FW-2:0], mosi_sync_q};
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        end
                    end
                    if (sck_fall) begin
                        tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    // Strobe is registered here so it is high exactly during COMMIT.
                    if (cs_rise) begin
                        state_q <= ST_COMMIT;
                        if (bit_cnt_q == CNT_FULL) begin
                            if (rx_q[FW-1]) begin
                                we_q  <= 1'b1;
                                num_q <= rx_q[FW-2 -: ADDR_WIDTH];
                                val_q <= rx_q[DATA_WIDTH-1:0];
                            end
                        end else begin
                            ferr_q <= sat_inc8(ferr_q);
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    assign o_SampleFull      = fifo_full;
    assign o_RegWriteEnable  = we_q;
    assign o_RegWriteNumber  = num_q;
    assign o_RegWriteValue   = val_q;
    assign o_UnderflowCount  = under_q;
    assign o_OverflowCount   = over_q;
    assign o_FrameErrorCount = ferr_q;
    assign o_SPI_MISO        = (state_q == ST_ACTIVE) ? tx_q[DATA_WIDTH-1] : 1'b0;

endmodule
